// File: rtl/vr_skid_buffer.sv
// vr_skid_buffer: registered valid/ready skid buffer, one word/cycle.
// Define HS_CNT_EN to add the xfer_cnt transfer counter output.
module vr_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] data_i,
`ifdef HS_CNT_EN
  output logic [31:0]      xfer_cnt,
`endif
  output logic [WIDTH-1:0] data_o
);

  // bit1 = main_v (valid_o), bit0 = ~skid_v (ready_o)
  typedef enum logic [1:0] {
    EMPTY = 2'b01,
    BUSY  = 2'b11,
    FULL  = 2'b10
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] main_d, main_n;
  logic [WIDTH-1:0] skid_d, skid_n;
  logic             acc, xfr;

  assign valid_o = state[1];
  assign ready_o = state[0];
  assign data_o  = main_d;

  assign acc = valid_i & state[0];
  assign xfr = state[1] & ready_i;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state  <= EMPTY;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      state  <= state_n;
      main_d <= main_n;
      skid_d <= skid_n;
    end
  end

  always_comb begin
    state_n = state;
    main_n  = main_d;
    skid_n  = skid_d;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          main_n  = data_i;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (acc && xfr) begin
          main_n = data_i;
        end else if (acc) begin
          skid_n  = data_i;
          state_n = FULL;
        end else if (xfr) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (xfr) begin
          main_n  = skid_d;
          state_n = BUSY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

`ifdef HS_CNT_EN
  always_ff @(posedge clk) begin
    if (rstn) begin
      xfer_cnt <= '0;
    end else if (xfr) begin
      xfer_cnt <= xfer_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vr_skid_buffer.sv
// tb_vr_skid_buffer: directed stimulus with a scoreboard queue.
// Optional HS_CNT_EN checks follow the same macro as the design.
module tb_vr_skid_buffer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         valid_i;
  logic         ready_o;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_i;
  logic [W-1:0] data_o;
`ifdef HS_CNT_EN
  logic [31:0]  xfer_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  vr_skid_buffer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_i  (data_i),
`ifdef HS_CNT_EN
    .xfer_cnt(xfer_cnt),
`endif
    .data_o  (data_o)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Drive at negedge, queue accepted word, return 1ns after the edge.
  task automatic cyc(input logic v, input logic [W-1:0] d,
                     input logic r, input logic rst);
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    rstn    = rst;
    if (rst) exp_q.delete();
    else if (v && ready_o) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens on the next posedge; check the word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rstn === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL mon_unexpected: got %0h want none", data_o);
        end else begin
          chk("mon_data", 64'(data_o), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    valid_i = 1'b1;
    data_i  = 5;
    ready_i = 1'b0;
    rstn    = 1'b1;

    // reset with a word presented
    cyc(1, 5, 0, 1);
    chk("rst_valid", 64'(valid_o), 0);
    chk("rst_ready", 64'(ready_o), 1);
    chk("rst_data", 64'(data_o), 0);

    // streaming
    for (int i = 0; i < 3; i++) cyc(0, W'(i), 1, 0);
    chk("idle_valid", 64'(valid_o), 0);
    for (int i = 3; i < 7; i++) begin
      cyc(1, W'(i), 1, 0);
      chk("str_valid", 64'(valid_o), 1);
      chk("str_data", 64'(data_o), 64'(i));
      chk("str_ready", 64'(ready_o), 1);
    end
    cyc(0, 7, 1, 0);
    chk("str_drain", 64'(valid_o), 0);

    // backpressure
    cyc(1, 10, 0, 0);
    chk("bp_d0", 64'(data_o), 10);
    chk("bp_r0", 64'(ready_o), 1);
    cyc(1, 11, 0, 0);
    chk("bp_d1", 64'(data_o), 10);
    chk("bp_r1", 64'(ready_o), 0);
    cyc(1, 12, 0, 0);
    chk("bp_d2", 64'(data_o), 10);
    chk("bp_v2", 64'(valid_o), 1);
    chk("bp_r2", 64'(ready_o), 0);
    cyc(0, 0, 1, 0);
    chk("bp_d3", 64'(data_o), 11);
    chk("bp_r3", 64'(ready_o), 1);
    cyc(0, 0, 1, 0);
    chk("bp_v4", 64'(valid_o), 0);
    chk("bp_hold", 64'(data_o), 11);

    // bubble
    cyc(1, 20, 1, 0);
    chk("bub_v0", 64'(valid_o), 1);
    chk("bub_d0", 64'(data_o), 20);
    cyc(0, 21, 1, 0);
    chk("bub_v1", 64'(valid_o), 0);
    chk("bub_d1", 64'(data_o), 20);
    cyc(1, 22, 1, 0);
    chk("bub_v2", 64'(valid_o), 1);
    chk("bub_d2", 64'(data_o), 22);
    cyc(0, 0, 1, 0);
    chk("bub_v3", 64'(valid_o), 0);

    // reset while FULL
    cyc(1, 30, 0, 0);
    cyc(1, 31, 0, 0);
    chk("full_r", 64'(ready_o), 0);
    cyc(0, 0, 1, 1);
    chk("frst_valid", 64'(valid_o), 0);
    chk("frst_ready", 64'(ready_o), 1);
    chk("frst_data", 64'(data_o), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      chk("frst_quiet", 64'(valid_o), 0);
    end
`ifdef HS_CNT_EN
    chk("cnt_rst", 64'(xfer_cnt), 0);
`endif

    // counted stream then stall
    for (int i = 40; i < 44; i++) cyc(1, W'(i), 1, 0);
    cyc(1, 44, 0, 0);
`ifdef HS_CNT_EN
    chk("cnt_4", 64'(xfer_cnt), 3);
`endif
    cyc(0, 0, 0, 0);
    chk("stall_d", 64'(data_o), 43);
    cyc(0, 0, 1, 0);
`ifdef HS_CNT_EN
    chk("cnt_after", 64'(xfer_cnt), 4);
`endif
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("stall_d2", 64'(data_o), 44);
`ifdef HS_CNT_EN
    chk("cnt_stall", 64'(xfer_cnt), 4);
`endif
    cyc(0, 0, 1, 0);
`ifdef HS_CNT_EN
    chk("cnt_5", 64'(xfer_cnt), 5);
    cyc(0, 0, 1, 1);
    chk("cnt_clr", 64'(xfer_cnt), 0);
`endif
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("q_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/vr_skid_buffer.md
Name: vr_skid_buffer

Overview:
- Single-stage valid/ready pipeline register (skid buffer) that cuts timing on both the forward path (valid/data) and the backward path (ready).
- Sustains one transfer per cycle and never drops or duplicates a word.
- Sits between any bus producer and consumer that use the valid/ready handshake.

Parameters:
- WIDTH, 32, data bus width in bits (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous reset, active-high despite the name (rstn=1 resets on the next clk edge).
- valid_i  input  1  upstream word valid.
- ready_o  output  1  block can accept a word; driven directly from a flop.
- valid_o  output  1  downstream word valid; driven directly from a flop.
- ready_i  input  1  downstream accepts a word.
- data_i  input  WIDTH  upstream data.
- data_o  output  WIDTH  downstream data; driven directly from a flop.
- xfer_cnt  output  32  present only with HS_CNT_EN (see Optional Feature).

Behaviour:
- Handshake events:
  - Accept: valid_i & ready_o at a rising edge.
  - Transfer: valid_o & ready_i at a rising edge.
- Storage: main register (main_v, main_d) drives valid_o/data_o. Skid register (skid_v, skid_d) holds one overflow word. ready_o = ~skid_v, registered.
- States: EMPTY (main_v=0, skid_v=0), BUSY (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1). skid_v=1 with main_v=0 is illegal and unreachable.
- EMPTY: accept -> main_d<=data_i, go BUSY. No accept -> stay.
- BUSY:
  - accept & transfer -> main_d<=data_i, stay.
  - accept & ~transfer -> skid_d<=data_i, go FULL; ready_o=0 from the next cycle.
  - ~accept & transfer -> go EMPTY.
  - Neither -> hold.
- FULL (ready_o=0, no accept possible):
  - transfer -> main_d<=skid_d, skid_v<=0, go BUSY; ready_o=1 next cycle.
  - No transfer -> hold everything.
- Latency: 1 cycle from accept to valid_o in the EMPTY/BUSY flow-through case. Throughput 1 word/cycle. Strict FIFO order.
- Stability: while valid_o=1 and ready_i=0, valid_o and data_o are held constant. data_o retains its last value when valid_o=0.
- ready_i may be asserted without valid_o; this has no effect.
- valid_i may drop at any time. No word is taken unless accept occurs.
- Reset (synchronous, dominates every other event at the same edge):
  - valid_o=0, ready_o=1, data_o=0, skid_v=0, skid_d=0.
  - Any word presented or held at that edge is discarded, including reset mid-stream in FULL.
  - The first accept is possible at the first edge after rstn deasserts.
- No combinational path from any input to any output.

Optional Feature:
- Macro HS_CNT_EN.
- Defined: adds output xfer_cnt[31:0], reset to 0 and incremented by 1 on every transfer edge. It wraps from 0xFFFFFFFF to 0. A transfer in the same cycle as reset is not counted.
- Undefined: the port and its counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rstn=1 for 1 edge with valid_i=1, data_i=5 -> after the edge valid_o=0, ready_o=1, data_o=0; nothing captured.
- Streaming: release reset; data_i increments 0,1,2,... each cycle; valid_i=ready_i=1 for 4 cycles (words 3..6) -> valid_o high for 4 cycles with data_o=3,4,5,6, each one cycle after its accept; ready_o stays 1.
- Backpressure: ready_i=0, valid_i=1, data_i=10,11,12 -> 10 in main, 11 in skid, ready_o=0 on the third cycle, 12 not accepted; data_o=10 stable. Then ready_i=1 -> outputs 10, then 11; ready_o returns to 1.
- Bubble: valid_i toggles 1,0,1 with ready_i=1 and data 20,x,22 -> valid_o=1,0,1 with data_o=20, then held at 20 while invalid, then 22.
- Reset in FULL: fill both registers, assert rstn -> next edge valid_o=0, ready_o=1; neither stored word ever appears on data_o.
- HS_CNT_EN: 4-word stream then 2 stalled cycles -> xfer_cnt=4 and unchanged during the stall; reset -> 0.
